// File: rtl/sigdel_interp_feeder.sv
`default_nettype none
// ==== sigdel_interp_feeder : FIFO-fed linear interpolator for the sigma-delta modulator input ====
// ==== rev 1.0                                                                                  ====
module sigdel_interp_feeder #(
  parameter int DATA_WIDTH = 24,
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_strobe,
  output logic                  underrun,
  output logic [7:0]            underrun_count,
  input  logic                  clear_underrun
);

  localparam int                DEPTH      = 1 << FIFO_LOG2;
  localparam int                ACC_W      = DATA_WIDTH + OSR_LOG2 + 1;
  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [FIFO_LOG2:0]  FIFO_FULL  = (FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [0:0] {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_LOG2-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0]   curr_q, curr_d;
  logic [DATA_WIDTH:0]     delta_q, delta_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [OSR_LOG2-1:0]     phase_q, phase_d;
  logic                    underrun_q, underrun_d;
  logic [7:0]              ucount_q, ucount_d;
  logic                    fifo_empty, push, do_load, do_hold;
  logic [DATA_WIDTH-1:0]   head;

  assign fifo_empty     = (count_q == '0);
  assign in_ready       = (count_q != FIFO_FULL);
  assign push           = in_valid && in_ready;
  assign head           = mem_q[rd_ptr_q];
  assign out_data       = acc_q[DATA_WIDTH+OSR_LOG2-1:OSR_LOG2];
  assign out_strobe     = do_load || do_hold;
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;

  always_comb begin
    state_d    = state_q;
    curr_d     = curr_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    do_load    = 1'b0;
    do_hold    = 1'b0;
    underrun_d = underrun_q;
    ucount_d   = ucount_q;

    if (enable) begin
      case (state_q)
        ST_PRIME: begin
          if (!fifo_empty) begin
            do_load = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (phase_q != PHASE_LAST) begin
            acc_d   = acc_q + {{OSR_LOG2{delta_q[DATA_WIDTH]}}, delta_q};
            phase_d = phase_q + 1'b1;
          end else if (!fifo_empty) begin
            do_load = 1'b1;
          end else begin
            do_hold = 1'b1;
          end
        end
        default: state_d = ST_PRIME;
      endcase
    end

    // Both load flavours restart the ramp from the current sample scaled up by OSR.
    if (do_load || do_hold) begin
      acc_d   = {curr_q[DATA_WIDTH-1], curr_q, {OSR_LOG2{1'b0}}};
      phase_d = '0;
    end
    if (do_load) begin
      delta_d = {head[DATA_WIDTH-1], head} - {curr_q[DATA_WIDTH-1], curr_q};
      curr_d  = head;
    end
    if (do_hold) begin
      delta_d = '0;
    end

    if (clear_underrun) begin
      underrun_d = 1'b0;
      ucount_d   = '0;
    end else if (do_hold) begin
      underrun_d = 1'b1;
      if (ucount_q != 8'hFF) ucount_d = ucount_q + 8'd1;
    end

    wr_ptr_d = push    ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(do_load);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PRIME;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      curr_q     <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      curr_q     <= curr_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_sigdel_interp_feeder.sv
`default_nettype none
// ==== tb_sigdel_interp_feeder : randomized + directed bench against a queue/ramp model ====
// ==== rev 1.0                                                                          ====
module tb_sigdel_interp_feeder;
  localparam int DW    = 24;
  localparam int OL    = 2;
  localparam int FL    = 2;
  localparam int OSR   = 1 << OL;
  localparam int DEPTH = 1 << FL;

  logic          clock = 1'b0;
  logic          reset_n, enable, in_valid, clear_underrun;
  logic [DW-1:0] in_data;
  logic          in_ready, out_strobe, underrun;
  logic [DW-1:0] out_data;
  logic [7:0]    underrun_count;

  always #5 clock = ~clock;

  sigdel_interp_feeder #(.DATA_WIDTH(DW), .OSR_LOG2(OL), .FIFO_LOG2(FL)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_strobe(out_strobe), .underrun(underrun), .underrun_count(underrun_count),
    .clear_underrun(clear_underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: sample queue, ramp from base to tgt indexed by k, underrun flag/count.
  int mq[$];
  bit primed;
  int base, tgt, k;
  bit uflag;
  int ucnt;
  int last_out;
  bit last_strobe;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int model_out();
    longint v;
    if (!primed) return 0;
    v = longint'(base) + ((longint'(k) * (longint'(tgt) - longint'(base))) >>> OL);
    return int'(v);
  endfunction

  function automatic bit exp_strobe(input bit en);
    if (!en) return 1'b0;
    if (!primed) return mq.size() > 0;
    return k == OSR-1;
  endfunction

  task automatic model_reset();
    mq.delete();
    primed = 0; base = 0; tgt = 0; k = 0; uflag = 0; ucnt = 0;
  endtask

  task automatic step(input bit v, input int d, input bit en, input bit clr);
    logic [DW-1:0] dd;
    bit push, hold, nonempty;
    dd = d[DW-1:0];
    in_valid = v; in_data = dd; enable = en; clear_underrun = clr;
    #1;
    last_out    = int'($signed(out_data));
    last_strobe = out_strobe;
    check("out_data", last_out, model_out());
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("out_strobe", out_strobe, exp_strobe(en));
    check("underrun", underrun, uflag);
    check("underrun_count", underrun_count, ucnt);
    @(posedge clock);
    push = v && (mq.size() < DEPTH);
    nonempty = mq.size() > 0;
    hold = 0;
    if (en) begin
      if (!primed) begin
        if (nonempty) begin base = tgt; tgt = mq.pop_front(); k = 0; primed = 1; end
      end else if (k == OSR-1) begin
        base = tgt;
        if (nonempty) tgt = mq.pop_front();
        else hold = 1;
        k = 0;
      end else begin
        k++;
      end
    end
    if (clr) begin uflag = 0; ucnt = 0; end
    else if (hold) begin uflag = 1; if (ucnt < 255) ucnt++; end
    if (push) mq.push_back(int'($signed(dd)));
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 0; in_data = '0; enable = 0; clear_underrun = 0;
    repeat (2) @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  int ramp_exp[9] = '{0, 100, 200, 300, 400, 200, 0, -200, -400};
  int fs[9];
  int frz;
  int guard;

  initial begin
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("prime_no_underrun", underrun, 0);

    // Ramp 0 -> 400 -> -400
    step(1, 400, 1, 0);
    step(1, -400, 1, 0);
    check("first_strobe", last_strobe, 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0);
      check("ramp", last_out, ramp_exp[i]);
    end
    check("ramp_underrun", underrun, 1);

    // Full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1000 * (i + 1), 0, 0);
    check("full_ready", in_ready, 0);
    step(1, 9999, 0, 0);
    step(0, 0, 1, 0);
    check("ready_after_load", in_ready, 1);
    repeat (24) step(0, 0, 1, 0);

    // Enable toggled mid-ramp
    do_reset();
    step(1, 800, 1, 0);
    step(1, -1200, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    frz = last_out;
    step(0, 0, 0, 0);
    check("freeze", last_out, frz);
    step(0, 0, 0, 0);
    check("freeze2", last_out, frz);
    repeat (10) step(0, 0, 1, 0);

    // Asynchronous reset mid-ramp
    do_reset();
    step(1, 2000, 1, 0);
    step(1, 3000, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", int'($signed(out_data)), 0);
    check("rst_ready", in_ready, 1);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 500, 1, 0);
    repeat (8) step(0, 0, 1, 0);

    // Starvation and count saturation
    do_reset();
    step(1, 1000, 1, 0);
    repeat (4 * 258 + 4) step(0, 0, 1, 0);
    check("hold_value", last_out, 1000);
    check("sat_count", underrun_count, 255);
    check("sat_flag", underrun, 1);
    guard = 0;
    while (k != OSR-1 && guard < 8) begin step(0, 0, 1, 0); guard++; end
    step(0, 0, 1, 1);
    check("clr_count", underrun_count, 0);
    check("clr_flag", underrun, 0);
    repeat (4) step(0, 0, 1, 0);

    // Full-scale endpoints
    do_reset();
    step(1, 'h800000, 1, 0);
    step(1, 'h7FFFFF, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0);
      fs[i] = last_out;
    end
    check("fs_bottom", fs[4], -8388608);
    for (int i = 5; i < 9; i++) check("fs_mono", fs[i] > fs[i-1], 1);
    check("fs_top", fs[8], 8388607);

    // Random traffic
    do_reset();
    repeat (1500)
      step($urandom_range(0, 9) < 4, int'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sigdel_interp_feeder.md
Name: sigdel_interp_feeder

Overview:
- Upstream stage of the 24-bit second-order sigma-delta modulator; drives the modulator's input_data port every clock.
- Accepts audio-rate signed PCM samples over a valid/ready handshake into a small FIFO.
- Linearly interpolates each sample up to the modulator clock rate, with OSR = 2^OSR_LOG2.
- On starvation it holds the last sample and flags underrun.

Parameters:
- DATA_WIDTH, 24: sample width, signed two's complement.
- OSR_LOG2, 6: log2 of oversampling ratio, i.e. enabled clocks per input sample; legal range 1..10.
- FIFO_LOG2, 2: log2 of FIFO depth (default 4 entries).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  modulator-rate tick; when low all interpolation state holds.
- in_data  in  DATA_WIDTH  signed PCM sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full.
- out_data  out  DATA_WIDTH  signed interpolated sample to the modulator input_data.
- out_strobe  out  1  one-cycle pulse on each sample-load cycle.
- underrun  out  1  sticky flag; set when a load finds the FIFO empty.
- underrun_count  out  8  saturating count of underrun loads.
- clear_underrun  in  1  synchronous clear of underrun and underrun_count.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state=PRIME, phase=0, curr=0, delta=0, acc=0.
  - Outputs: out_data=0, out_strobe=0, underrun=0, underrun_count=0, in_ready=1.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on a load event.
  - in_ready is low when full; no push-while-full.
  - No bypass: a push and a load in the same cycle with the FIFO empty is an underrun; the pushed word is popped at the next load.
- Registers:
  - curr: DATA_WIDTH.
  - delta: DATA_WIDTH+1, signed.
  - acc: DATA_WIDTH+OSR_LOG2+1, signed.
  - phase: OSR_LOG2 bits.
  - out_data = acc[DATA_WIDTH+OSR_LOG2-1:OSR_LOG2], i.e. arithmetic truncation toward -inf. out_data is directly registered with no added latency.
- Load event (head h):
  - acc <= sign-extended curr << OSR_LOG2.
  - delta <= h - curr.
  - curr <= h.
  - phase <= 0.
  - out_strobe=1 for that cycle.
- Interpolation is range-safe: acc stays between curr_old and h, so out_data never overflows. No saturation logic is needed.
- State PRIME: phase and acc hold, out_data=0.
  - If enable && FIFO non-empty: load (curr=0, so the output ramps from 0 to the first sample), then go to RUN.
  - Underrun is never flagged in PRIME.
- State RUN, only when enable=1:
  - phase != OSR-1: acc <= acc + sign-extended delta; phase <= phase+1.
  - phase == OSR-1, FIFO non-empty: load.
  - phase == OSR-1, FIFO empty: hold-load.
    - acc <= curr << OSR_LOG2, delta <= 0, phase <= 0.
    - out_strobe=1.
    - Set underrun; underrun_count increments, saturating at 255.
    - Stay in RUN.
- Per sample, out_data takes the values curr_old + floor(k*delta/OSR) for k=0..OSR-1, one per enabled cycle, and equals h exactly at the next load.
- enable=0: out_data, phase, acc and state hold; out_strobe=0; the FIFO still accepts pushes.
- clear_underrun has priority over a same-cycle underrun event. Result: flag=0, count=0.
- Reset asserted mid-operation: immediate return to reset values; FIFO contents discarded.

Test Plan:
- OSR_LOG2=2, enable=1, push 400 into an empty block:
  - out_strobe on the first cycle after push visibility.
  - out_data then reads 0, 100, 200, 300, then 400 at the next load (FIFO has a second word).
- Push 400 then -400, OSR_LOG2=2, continuous enable:
  - After 400 is reached, out_data reads 400, 200, 0, -200, then -400.
- Starvation: push only 1000, OSR_LOG2=2:
  - out_data ramps to 1000 and holds at 1000.
  - underrun=1 and underrun_count increments every 4 cycles.
  - Count saturates at 255 after 255 hold-loads.
  - clear_underrun returns both to 0.
- Full FIFO: push 4 words with no enable:
  - in_ready=0 on the 5th attempt; the 5th word is not stored.
  - After the first load, in_ready=1.
- enable toggled 1-0-1 mid-ramp:
  - out_data and phase frozen while enable=0; the ramp resumes with identical values afterward.
- reset_n pulsed low mid-ramp without a clock edge:
  - out_data=0 and in_ready=1 immediately.
  - state PRIME; a new push restarts the ramp from 0.
- Full-scale endpoints, default params:
  - Push 0x800000 then 0x7FFFFF; no overflow.
  - out_data is monotonic rising and reaches 0x7FFFFF at the next load.
